// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Grants one request at a time, runs it through EXEC and holds the result in RESP until it is taken.
//
//   state | meaning
//   IDLE  | waiting for a request; grant issued combinationally
//   EXEC  | latched operands drive the ALU; result captured this cycle
//   RESP  | response held on rsp_* until rsp_ready
module alu_rr_arbiter #(
  parameter int PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_card,
  input  logic [4:0]  req0_shft,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_card,
  input  logic [4:0]  req1_shft,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_f,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_card,
  output logic [4:0]  alu_shft,
  input  logic [31:0] alu_f,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic PRIO_INIT = (PRIO_RESET != 0);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  card_q, card_d;
  logic [4:0]  shft_q, shft_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic        gnt_id;

  function automatic logic card_legal(input logic [5:0] c);
    case (c)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b001010, 6'b000000, 6'b111110: card_legal = 1'b1;
      default:                                    card_legal = 1'b0;
    endcase
  endfunction

  // Pointer only arbitrates a true conflict; a lone requester always wins.
  assign gnt_id = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    a_d        = a_q;
    b_d        = b_q;
    card_d     = card_q;
    shft_d     = shft_q;
    id_d       = id_q;
    res_d      = res_q;
    err_d      = err_q;
    ops_done_d = ops_done_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          id_d       = gnt_id;
          a_d        = gnt_id ? req1_a    : req0_a;
          b_d        = gnt_id ? req1_b    : req0_b;
          card_d     = gnt_id ? req1_card : req0_card;
          shft_d     = gnt_id ? req1_shft : req0_shft;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (card_legal(card_q)) begin
          res_d = alu_f;
          err_d = 1'b0;
        end else begin
          res_d = 32'd0;
          err_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          prio_d     = ~id_q;
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= PRIO_INIT;
      a_q        <= '0;
      b_q        <= '0;
      card_q     <= '0;
      shft_q     <= '0;
      id_q       <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      a_q        <= a_d;
      b_q        <= b_d;
      card_q     <= card_d;
      shft_q     <= shft_d;
      id_q       <= id_d;
      res_q      <= res_d;
      err_q      <= err_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_card = card_q;
  assign alu_shft = shft_q;
  assign rsp_id   = id_q;
  assign rsp_f    = res_q;
  assign rsp_err  = err_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural model of the shared ALU.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_card, req1_card;
  logic [4:0]  req0_shft, req1_shft;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_f;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [5:0]  alu_card;
  logic [4:0]  alu_shft;
  logic [15:0] ops_done;

  int checks   = 0;
  int failures = 0;

  alu_rr_arbiter #(.PRIO_RESET(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_card(req0_card), .req0_shft(req0_shft),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_card(req1_card), .req1_shft(req1_shft),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_card(alu_card), .alu_shft(alu_shft),
    .alu_f(alu_f), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Illegal codes return a nonzero pattern so a missing err path shows up.
  always_comb begin
    alu_f = 32'hDEADBEEF;
    case (alu_card)
      6'b100000: alu_f = alu_a + alu_b;
      6'b100010: alu_f = alu_a - alu_b;
      6'b100100: alu_f = alu_a & alu_b;
      6'b100101: alu_f = alu_a | alu_b;
      6'b100110: alu_f = alu_a ^ alu_b;
      6'b001010: alu_f = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'b000000: alu_f = alu_b << alu_shft;
      6'b111110: alu_f = ~(alu_a | alu_b);
      default:   alu_f = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_card = '0; req0_shft = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_card = '0; req1_shft = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
    chk("rst_rsp_f", rsp_f, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_card", {26'd0, alu_card}, 32'd0);
    rst = 1'b0;

    // req0 ADD 5+3
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_card = 6'b100000; req0_shft = 5'd0;
    req0_valid = 1'b1;
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("add_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_exec_alu_a", alu_a, 32'd5);
    chk("add_exec_alu_b", alu_b, 32'd3);
    @(negedge clk);
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("add_rsp_f", rsp_f, 32'd8);
    chk("add_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    chk("add_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_ops_done", {16'd0, ops_done}, 32'd1);

    // contention after reset: req0 SUB first, then req1 SLL
    rst = 1'b1;
    #1;
    chk("rst2_ops_done", {16'd0, ops_done}, 32'd0);
    rst = 1'b0;
    req0_a = 32'd10; req0_b = 32'd4; req0_card = 6'b100010; req0_shft = 5'd0;
    req1_a = 32'd0;  req1_b = 32'd1; req1_card = 6'b000000; req1_shft = 5'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("both_ready0", {31'd0, req0_ready}, 32'd1);
    chk("both_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("exec_hold_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    chk("sub_rsp_f", rsp_f, 32'd6);
    chk("sub_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("resp_hold_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("ptr1_ready1", {31'd0, req1_ready}, 32'd1);
    chk("ptr1_ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("sll_rsp_f", rsp_f, 32'd16);
    chk("sll_rsp_id", {31'd0, rsp_id}, 32'd1);
    chk("sll_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    chk("sll_ops_done", {16'd0, ops_done}, 32'd2);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("ptr0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("ptr0_ready1", {31'd0, req1_ready}, 32'd0);

    // lone req1 with illegal card wins despite pointer at 0
    req0_valid = 1'b0;
    req1_a = 32'd7; req1_b = 32'd9; req1_card = 6'b111111; req1_shft = 5'd0;
    #1;
    chk("single_ready1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("ill_rsp_f", rsp_f, 32'd0);
    chk("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_rsp_id", {31'd0, rsp_id}, 32'd1);
    @(negedge clk);
    chk("ill_ops_done", {16'd0, ops_done}, 32'd3);

    // back-pressure: rsp_ready low for three RESP cycles
    rsp_ready = 1'b0;
    req0_a = 32'h0000_FF00; req0_b = 32'h0000_0FF0; req0_card = 6'b100100;
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_a = 32'd1; req1_b = 32'd1; req1_card = 6'b100000;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_f", rsp_f, 32'h0000_0F00);
      chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    #1;
    chk("bp_last_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_ops_done", {16'd0, ops_done}, 32'd4);

    // reset during EXEC aborts the XOR
    req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F; req0_card = 6'b100110;
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ops_done", {16'd0, ops_done}, 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_alu_card", {26'd0, alu_card}, 32'd0);
    chk("abort_rsp_f", rsp_f, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ops_still0", {16'd0, ops_done}, 32'd0);
    req0_valid = 1'b1;
    #1;
    chk("xor_ready0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("xor_rsp_f", rsp_f, 32'h0000_00FF);
    chk("xor_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("xor_ops_done", {16'd0, ops_done}, 32'd1);

    // completion counter wrap, preloaded to skip 65534 transactions
    force dut.ops_done_q = 16'hFFFE;
    #1;
    release dut.ops_done_q;
    #1;
    chk("wrap_preload", {16'd0, ops_done}, 32'h0000_FFFE);
    req0_a = 32'd1; req0_b = 32'd1; req0_card = 6'b100000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      chk("wrap_rsp_f", rsp_f, 32'd2);
      @(negedge clk);
      chk("wrap_ops_done", {16'd0, ops_done}, (i == 0) ? 32'h0000_FFFF : 32'h0000_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
